// File: rtl/sdram_init_refresh.sv
// SDRAM power-up init sequencer and periodic auto-refresh engine.
// Optional macro SDRAM_REF_DEBT_EN: keep up to 3 postponed refreshes and run them back-to-back.
// Wait-state counters load T_x-2, so T_RP, T_RC and T_MRD must each be at least 2.
module sdram_init_refresh #(
    parameter int unsigned INIT_WAIT  = 20000,
    parameter int unsigned REF_PERIOD = 1560,
    parameter int unsigned T_RP       = 3,
    parameter int unsigned T_RC       = 7,
    parameter int unsigned T_MRD      = 2,
    parameter logic [11:0] MODE_REG   = 12'h020
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ref_ack,
    output logic        init_done,
    output logic        ref_req,
    output logic        cmd_own,
    output logic        zs_cke,
    output logic        zs_cs_n,
    output logic        zs_ras_n,
    output logic        zs_cas_n,
    output logic        zs_we_n,
    output logic [11:0] zs_addr,
    output logic [1:0]  zs_ba
);

    localparam int unsigned MAX_A   = (INIT_WAIT > T_RC) ? INIT_WAIT : T_RC;
    localparam int unsigned MAX_B   = (T_RP > T_MRD) ? T_RP : T_MRD;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned TMR_W   = $clog2(REF_PERIOD + 1);
`ifdef SDRAM_REF_DEBT_EN
    localparam int unsigned PEND_W  = 2;
`else
    localparam int unsigned PEND_W  = 1;
`endif

    localparam logic [3:0]  CMD_NOP = 4'b0111;
    localparam logic [3:0]  CMD_PRE = 4'b0010;
    localparam logic [3:0]  CMD_REF = 4'b0001;
    localparam logic [3:0]  CMD_LMR = 4'b0000;
    localparam logic [11:0] A10     = 12'h400;

    typedef enum logic [3:0] {
        S_RST, S_WAIT, S_PRE, S_PRE_WT, S_REF1, S_REF1_WT, S_REF2, S_REF2_WT,
        S_MRS, S_MRS_WT, S_IDLE, S_RPRE, S_RPRE_WT, S_RREF, S_RREF_WT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic               init_done_q, init_done_d;
    logic               ref_req_q, ref_req_d;
    logic               cmd_own_q, cmd_own_d;
    logic               cke_q, cke_d;
    logic [3:0]         cmd_q, cmd_d;
    logic [11:0]        addr_q, addr_d;
    logic [1:0]         ba_q, ba_d;
    logic               tick, dec, cnt_zero;

    always_comb begin
        cnt_zero = (cnt_q == '0);
        tick     = init_done_q && (timer_q == TMR_W'(REF_PERIOD - 1));
        dec      = (state_q == S_RREF_WT) && cnt_zero;

        timer_d = '0;
        if (init_done_q) timer_d = tick ? '0 : timer_q + TMR_W'(1);

        pend_d = pend_q;
        if (tick && !dec && (pend_q != '1)) pend_d = pend_q + PEND_W'(1);
        else if (dec && !tick)              pend_d = pend_q - PEND_W'(1);
        ref_req_d = (pend_d != '0);

        state_d     = state_q;
        cnt_d       = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
        cmd_d       = CMD_NOP;
        addr_d      = '0;
        ba_d        = '0;
        cke_d       = 1'b1;
        init_done_d = init_done_q;
        cmd_own_d   = cmd_own_q;

        // Outputs are computed for the state being entered, so each command appears on the edge it is scheduled for.
        case (state_q)
            S_RST: begin
                state_d = S_WAIT;
                cnt_d   = CNT_W'(INIT_WAIT - 1);
            end
            S_WAIT: if (cnt_zero) begin
                state_d = S_PRE;
                cmd_d   = CMD_PRE;
                addr_d  = A10;
            end
            S_PRE: begin
                state_d = S_PRE_WT;
                cnt_d   = CNT_W'(T_RP - 2);
            end
            S_PRE_WT: if (cnt_zero) begin
                state_d = S_REF1;
                cmd_d   = CMD_REF;
            end
            S_REF1: begin
                state_d = S_REF1_WT;
                cnt_d   = CNT_W'(T_RC - 2);
            end
            S_REF1_WT: if (cnt_zero) begin
                state_d = S_REF2;
                cmd_d   = CMD_REF;
            end
            S_REF2: begin
                state_d = S_REF2_WT;
                cnt_d   = CNT_W'(T_RC - 2);
            end
            S_REF2_WT: if (cnt_zero) begin
                state_d = S_MRS;
                cmd_d   = CMD_LMR;
                addr_d  = MODE_REG;
            end
            S_MRS: begin
                state_d = S_MRS_WT;
                cnt_d   = CNT_W'(T_MRD - 2);
            end
            S_MRS_WT: if (cnt_zero) begin
                state_d     = S_IDLE;
                init_done_d = 1'b1;
                cmd_own_d   = 1'b0;
            end
            S_IDLE: if (ref_req_q && ref_ack) begin
                state_d   = S_RPRE;
                cmd_d     = CMD_PRE;
                addr_d    = A10;
                cmd_own_d = 1'b1;
            end else begin
                cmd_own_d = 1'b0;
            end
            S_RPRE: begin
                state_d = S_RPRE_WT;
                cnt_d   = CNT_W'(T_RP - 2);
            end
            S_RPRE_WT: if (cnt_zero) begin
                state_d = S_RREF;
                cmd_d   = CMD_REF;
            end
            S_RREF: begin
                state_d = S_RREF_WT;
                cnt_d   = CNT_W'(T_RC - 2);
            end
            S_RREF_WT: if (cnt_zero) begin
                state_d = S_IDLE;
`ifdef SDRAM_REF_DEBT_EN
                // Hold the bus through the IDLE gap while more refreshes are owed.
                cmd_own_d = (pend_d != '0);
`else
                cmd_own_d = 1'b0;
`endif
            end
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_RST;
            cnt_q       <= '0;
            timer_q     <= '0;
            pend_q      <= '0;
            init_done_q <= 1'b0;
            ref_req_q   <= 1'b0;
            cmd_own_q   <= 1'b1;
            cke_q       <= 1'b0;
            cmd_q       <= 4'b1111;
            addr_q      <= '0;
            ba_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            pend_q      <= pend_d;
            init_done_q <= init_done_d;
            ref_req_q   <= ref_req_d;
            cmd_own_q   <= cmd_own_d;
            cke_q       <= cke_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            ba_q        <= ba_d;
        end
    end

    assign init_done = init_done_q;
    assign ref_req   = ref_req_q;
    assign cmd_own   = cmd_own_q;
    assign zs_cke    = cke_q;
    assign zs_cs_n   = cmd_q[3];
    assign zs_ras_n  = cmd_q[2];
    assign zs_cas_n  = cmd_q[1];
    assign zs_we_n   = cmd_q[0];
    assign zs_addr   = addr_q;
    assign zs_ba     = ba_q;

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Directed bench for sdram_init_refresh with short timing parameters.
module tb_sdram_init_refresh;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ref_ack = 1'b0;
    logic        init_done, ref_req, cmd_own, zs_cke;
    logic        zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n;
    logic [11:0] zs_addr;
    logic [1:0]  zs_ba;
    logic [3:0]  cmd;

    int cyc = -1;
    int total = 0;
    int bad = 0;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] LMR = 4'b0000;

    sdram_init_refresh #(
        .INIT_WAIT (10),
        .REF_PERIOD(50),
        .T_RP      (3),
        .T_RC      (7),
        .T_MRD     (2),
        .MODE_REG  (12'h020)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ref_ack  (ref_ack),
        .init_done(init_done),
        .ref_req  (ref_req),
        .cmd_own  (cmd_own),
        .zs_cke   (zs_cke),
        .zs_cs_n  (zs_cs_n),
        .zs_ras_n (zs_ras_n),
        .zs_cas_n (zs_cas_n),
        .zs_we_n  (zs_we_n),
        .zs_addr  (zs_addr),
        .zs_ba    (zs_ba)
    );

    always #5 clk = ~clk;
    assign cmd = {zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_init_done"}, 32'(init_done), 32'd0);
        chk({tag, "_ref_req"},   32'(ref_req),   32'd0);
        chk({tag, "_cmd_own"},   32'(cmd_own),   32'd1);
        chk({tag, "_cke"},       32'(zs_cke),    32'd0);
        chk({tag, "_cmd"},       32'(cmd),       32'hF);
        chk({tag, "_addr"},      32'(zs_addr),   32'd0);
        chk({tag, "_ba"},        32'(zs_ba),     32'd0);
    endtask

    function automatic logic [3:0] init_cmd(input int c);
        if (c == 10) return PRE;
        if (c == 13 || c == 20) return REF;
        if (c == 27) return LMR;
        return NOP;
    endfunction

    function automatic logic [11:0] init_addr(input int c);
        if (c == 10) return 12'h400;
        if (c == 27) return 12'h020;
        return 12'h000;
    endfunction

    initial begin
        int npre;
        int exp_pre;
        logic exp_own250;
`ifdef SDRAM_REF_DEBT_EN
        exp_pre    = 3;
        exp_own250 = 1'b1;
`else
        exp_pre    = 1;
        exp_own250 = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");

        // Release reset between edges; ack held high through init must be ignored.
        #2 reset_n = 1'b1;
        ref_ack = 1'b1;
        for (int c = 0; c <= 40; c++) begin
            step();
            chk("init_cmd",  32'(cmd),       32'(init_cmd(c)));
            chk("init_addr", 32'(zs_addr),   32'(init_addr(c)));
            chk("init_ba",   32'(zs_ba),     32'd0);
            chk("init_cke",  32'(zs_cke),    32'd1);
            chk("init_done", 32'(init_done), 32'(c >= 29));
            chk("init_own",  32'(cmd_own),   32'(c < 29));
            chk("init_rreq", 32'(ref_req),   32'd0);
        end
        ref_ack = 1'b0;

        while (cyc < 78) begin
            step();
            chk("rreq_low", 32'(ref_req), 32'd0);
        end
        step();
        chk("rreq_rise", 32'(ref_req), 32'd1);

        while (cyc < 85) begin
            step();
            chk("idle_own", 32'(cmd_own), 32'd0);
        end
        ref_ack = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            step();
            if (k == 0) ref_ack = 1'b0;
            chk("ref_cmd",  32'(cmd),     32'((cyc == 86) ? PRE : (cyc == 89) ? REF : NOP));
            chk("ref_addr", 32'(zs_addr), 32'((cyc == 86) ? 12'h400 : 12'h000));
            chk("ref_own",  32'(cmd_own), 32'(cyc < 96));
        end
        chk("ref_req_clr", 32'(ref_req), 32'd0);

        while (cyc < 235) step();
        chk("post_rreq", 32'(ref_req), 32'd1);
        ref_ack = 1'b1;
        npre = 0;
        while (cyc < 275) begin
            step();
            if (cmd == PRE) npre++;
            if (cyc == 250) chk("post_own_gap", 32'(cmd_own), 32'(exp_own250));
        end
        ref_ack = 1'b0;
        chk("post_npre", 32'(npre), 32'(exp_pre));
        chk("post_own_end", 32'(cmd_own), 32'd0);
        chk("post_rreq_end", 32'(ref_req), 32'd0);

        while (cyc < 279) step();
        chk("mid_rreq", 32'(ref_req), 32'd1);
        ref_ack = 1'b1;
        step();
        ref_ack = 1'b0;
        chk("mid_pre", 32'(cmd), 32'(PRE));
        while (cyc < 286) step();
        chk("mid_own", 32'(cmd_own), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk_reset("async");
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        cyc = -1;
        for (int c = 0; c <= 12; c++) begin
            step();
            chk("re_cmd",  32'(cmd),       32'(init_cmd(c)));
            chk("re_cke",  32'(zs_cke),    32'd1);
            chk("re_done", 32'(init_done), 32'd0);
            chk("re_own",  32'(cmd_own),   32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_init_refresh.md
# sdram_init_refresh

Power-up initialisation and periodic auto-refresh sequencer for the 32-bit SDRAM behind `sram_controller`. After reset it owns the SDRAM command pins and runs the JEDEC init sequence: wait, PRECHARGE ALL, two AUTO REFRESH, then LOAD MODE with CAS latency 2, sequential wrap, burst length 1. It then raises periodic refresh requests and, once the main access FSM grants the bus, drives PRECHARGE ALL plus AUTO REFRESH. The controller's output mux selects this block's command bus whenever `cmd_own` is high.

## Interface
- `INIT_WAIT`, 20000: NOP cycles after reset before the first command (200 µs at 100 MHz).
- `REF_PERIOD`, 1560: cycles between refresh ticks (15.6 µs at 100 MHz).
- `T_RP`, 3: PRECHARGE-to-next-command spacing, in cycles.
- `T_RC`, 7: AUTO REFRESH-to-next-command spacing, in cycles.
- `T_MRD`, 2: LOAD MODE-to-ready spacing, in cycles.
- `MODE_REG`, 12'h020: value driven on `zs_addr` during LOAD MODE.

Ports:
- `clk`  in  1  system clock, 100/130 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ref_ack`  in  1  main FSM grant: bus idle, refresh may start.
- `init_done`  out  1  init complete; main FSM may accept accesses.
- `ref_req`  out  1  at least one refresh pending.
- `cmd_own`  out  1  this block drives the SDRAM command pins.
- `zs_cke`, `zs_cs_n`, `zs_ras_n`, `zs_cas_n`, `zs_we_n`  out  1 each  SDRAM control.
- `zs_addr`  out  12  address / mode word.
- `zs_ba`  out  2  bank address.

## Operation
- Commands as {cs_n, ras_n, cas_n, we_n}:
  - NOP = 0111.
  - PRECHARGE ALL = 0010, with `zs_addr[10]`=1.
  - AUTO REFRESH = 0001.
  - LOAD MODE = 0000, with `zs_addr`=`MODE_REG` and `zs_ba`=0.
- Outside LOAD MODE and PRECHARGE, `zs_addr`=0 and `zs_ba`=0.
- Each command lasts exactly one cycle and is followed by NOPs until its spacing parameter expires.
- Init states, in order:
  - RST.
  - WAIT (`INIT_WAIT` NOPs).
  - PRE.
  - PRE_WT (`T_RP`-1 NOPs).
  - REF1.
  - REF1_WT (`T_RC`-1 NOPs).
  - REF2.
  - REF2_WT (`T_RC`-1 NOPs).
  - MRS.
  - MRS_WT (`T_MRD`-1 NOPs).
  - IDLE.
- Refresh states: IDLE → RPRE → RPRE_WT (`T_RP`-1) → RREF → RREF_WT (`T_RC`-1) → IDLE.
- Refresh timer:
  - Counts 0..`REF_PERIOD`-1, starting at 0 on the cycle `init_done` rises, and wraps.
  - Its terminal count is a tick, which increments the pending count. The timer never stops after init.
- `ref_req` = (pending ≠ 0).
- Refresh grant:
  - `ref_ack` is sampled only in IDLE with `ref_req`=1. That sample moves the FSM to RPRE.
  - `ref_ack` at any other time (init, mid-refresh, `ref_req`=0) is ignored.
- Pending decrements on the last cycle of RREF_WT.
- A tick coinciding with a decrement leaves pending unchanged.
- `cmd_own`=1 from reset through MRS_WT and during RPRE..RREF_WT; 0 in IDLE.
- `zs_cke`=1 from the first cycle of WAIT onward.

## Timing
- Reset values, asserted asynchronously on `reset_n` low:
  - `init_done`=0, `ref_req`=0, `cmd_own`=1.
  - `zs_cke`=0; `zs_cs_n`, `zs_ras_n`, `zs_cas_n`, `zs_we_n`=1.
  - `zs_addr`=0, `zs_ba`=0.
  - Pending=0, timer=0.
- All outputs are registered.
- Cycle 0 is the first rising edge with `reset_n` high. Command schedule, with W=`INIT_WAIT`:
  - WAIT (NOPs) occupies cycles 0..W-1.
  - PRE at cycle W.
  - REF1 at W+`T_RP`.
  - REF2 at W+`T_RP`+`T_RC`.
  - MRS at W+`T_RP`+2·`T_RC`.
  - `init_done` high from W+`T_RP`+2·`T_RC`+`T_MRD` and stays high until reset.
- Refresh with the ack sampled at cycle A:
  - `cmd_own` rises at A+1 together with PRE.
  - REF at A+1+`T_RP`.
  - `cmd_own` falls, and FSM is back in IDLE, at A+1+`T_RP`+`T_RC`.
- If pending is still ≠ 0 and `ref_ack` is high in that IDLE cycle, the next refresh starts the following cycle.
- Reset mid-operation aborts immediately. The full init repeats on release.

## Configuration
- `SDRAM_REF_DEBT_EN` defined:
  - Pending is a 2-bit saturating counter, so up to 3 postponed refreshes are retained.
  - A single `ref_ack` held high runs them back-to-back, with `cmd_own` continuously high. Between them the FSM passes through IDLE for one cycle, with `cmd_own` still high.
- Not defined:
  - Pending is a single bit. Ticks arriving while it is set are dropped.
  - `cmd_own` drops in IDLE between refreshes.

## Test plan
- Init schedule, with `INIT_WAIT`=10, `T_RP`=3, `T_RC`=7, `T_MRD`=2 and reset released:
  - PRE at cycle 10 with `zs_addr[10]`=1.
  - AUTO REFRESH at cycles 13 and 20.
  - LOAD MODE at cycle 27 with `zs_addr`=12'h020, `zs_ba`=0.
  - `init_done`=1 from cycle 29; `zs_cke`=1 from cycle 0.
- Refresh handshake, with `REF_PERIOD`=50:
  - `ref_req` rises 50 cycles after `init_done`.
  - `ref_ack` pulsed at cycle A gives PRE at A+1 and REF at A+4.
  - `cmd_own` low at A+11; `ref_req` low at A+11.
- Postponement: hold `ref_ack`=0 for 3 periods, then hold it high.
  - With the macro: 3 refreshes back-to-back.
  - Without the macro: exactly 1 refresh.
- Spurious grants: `ref_ack`=1 during init and while `ref_req`=0 → no command other than the init sequence / NOP; `cmd_own` unchanged.
- Reset mid-refresh: `reset_n` low during RREF_WT → all outputs take reset values without a clock edge; on release the init sequence restarts at cycle 0.
